// File: rtl/predicate_speculation_tracker.sv
// Predicate speculation tracker: queues predicted predicates, commits or squashes on resolve.
// Optional PREDICATE_SPECULATION_STATS_EN adds saturating hit/miss counters.
module predicate_speculation_tracker #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned TAG_WIDTH       = 3,
  parameter int unsigned RECOVERY_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     issue_valid,
  input  logic                     issue_prediction,
  input  logic [TAG_WIDTH-1:0]     issue_tag,
  output logic                     issue_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_value,
  output logic                     commit_valid,
  output logic [TAG_WIDTH-1:0]     commit_tag,
  output logic                     squash,
  output logic [TAG_WIDTH-1:0]     squash_tag,
  output logic [$clog2(DEPTH):0]   outstanding_count
`ifdef PREDICATE_SPECULATION_STATS_EN
  ,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RC_W  = $clog2(RECOVERY_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [RC_W-1:0]  RC_INIT   = RC_W'(RECOVERY_CYCLES);

  typedef struct packed {
    logic                 pred;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic {ACTIVE = 1'b0, RECOVER = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             commit_valid_q, squash_q;
  logic [TAG_WIDTH-1:0] commit_tag_q, squash_tag_q;

  entry_t head;
  logic   resolve_eff, hit, miss, push;

  // Resolve classification against the oldest entry; a mismatch overrides any same-cycle issue.
  always_comb begin
    head        = fifo_q[rd_ptr_q];
    resolve_eff = enable && resolve_valid && (count_q != '0);
    hit         = resolve_eff && (resolve_value == head.pred);
    miss        = resolve_eff && (resolve_value != head.pred);
    push        = issue_valid && issue_ready && !miss;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACTIVE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // FSM next state; the recovery counter only advances on enabled cycles.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (enable) begin
      case (state_q)
        ACTIVE: begin
          if (miss) begin
            state_d = RECOVER;
            rcnt_d  = RC_INIT;
          end
        end
        RECOVER: begin
          if (rcnt_q <= RC_W'(1)) begin
            state_d = ACTIVE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q - RC_W'(1);
          end
        end
        default: state_d = ACTIVE;
      endcase
    end
  end

  // FSM outputs: depend on registered state and enable only.
  always_comb begin
    issue_ready = enable && (state_q == ACTIVE) && (count_q < DEPTH_C);
  end

  // Pointer and occupancy next state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (miss) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (hit)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(hit);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      squash_q       <= 1'b0;
      commit_tag_q   <= '0;
      squash_tag_q   <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      commit_valid_q <= hit;
      squash_q       <= miss;
      if (hit)  commit_tag_q <= head.tag;
      if (miss) squash_tag_q <= head.tag;
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{pred: issue_prediction, tag: issue_tag};
  end

  assign commit_valid      = commit_valid_q;
  assign commit_tag        = commit_tag_q;
  assign squash            = squash_q;
  assign squash_tag        = squash_tag_q;
  assign outstanding_count = count_q;

`ifdef PREDICATE_SPECULATION_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit  && (hit_q  != 16'hFFFF)) hit_q  <= hit_q  + 16'd1;
      if (miss && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_predicate_speculation_tracker.sv
// Randomized bench for predicate_speculation_tracker with a queue-based reference model.
module tb_predicate_speculation_tracker;

  localparam int DEPTH = 4;
  localparam int RC    = 2;

  logic       clock = 1'b0;
  logic       reset, enable, issue_valid, issue_prediction, resolve_valid, resolve_value;
  logic [2:0] issue_tag;
  logic       issue_ready, commit_valid, squash;
  logic [2:0] commit_tag, squash_tag;
  logic [2:0] outstanding_count;
`ifdef PREDICATE_SPECULATION_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  predicate_speculation_tracker #(.DEPTH(DEPTH), .TAG_WIDTH(3), .RECOVERY_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .issue_valid(issue_valid), .issue_prediction(issue_prediction), .issue_tag(issue_tag),
    .issue_ready(issue_ready),
    .resolve_valid(resolve_valid), .resolve_value(resolve_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .squash(squash), .squash_tag(squash_tag),
    .outstanding_count(outstanding_count)
`ifdef PREDICATE_SPECULATION_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  // Reference model: a queue of outstanding speculations plus a stall-cycles-left counter.
  typedef struct packed { logic p; logic [2:0] t; } ent_t;
  ent_t       mq[$];
  int         rec_left = 0;
  bit         m_cv = 0, m_sq = 0;
  logic [2:0] m_ct = '0, m_st = '0;
  int         m_hit = 0, m_miss = 0;
  bit         m_rdy, m_mis;

  function automatic bit model_ready();
    return enable && (rec_left == 0) && (mq.size() < DEPTH);
  endfunction

  always @(posedge clock) begin
    m_rdy = model_ready();
    m_mis = 0;
    if (reset) begin
      mq.delete(); rec_left = 0; m_cv = 0; m_sq = 0; m_ct = '0; m_st = '0; m_hit = 0; m_miss = 0;
    end else if (!enable) begin
      m_cv = 0; m_sq = 0;
    end else begin
      m_cv = 0; m_sq = 0;
      if (rec_left > 0) rec_left--;
      if (resolve_valid && mq.size() > 0) begin
        if (resolve_value == mq[0].p) begin
          m_cv = 1; m_ct = mq[0].t; void'(mq.pop_front());
          if (m_hit < 65535) m_hit++;
        end else begin
          m_sq = 1; m_st = mq[0].t; mq.delete(); rec_left = RC; m_mis = 1;
          if (m_miss < 65535) m_miss++;
        end
      end
      if (issue_valid && m_rdy && !m_mis) mq.push_back('{p: issue_prediction, t: issue_tag});
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (checking) begin
      chk("issue_ready", 32'(issue_ready), 32'(model_ready()));
      chk("commit_valid", 32'(commit_valid), 32'(m_cv));
      chk("commit_tag", 32'(commit_tag), 32'(m_ct));
      chk("squash", 32'(squash), 32'(m_sq));
      chk("squash_tag", 32'(squash_tag), 32'(m_st));
      chk("outstanding_count", 32'(outstanding_count), 32'(mq.size()));
`ifdef PREDICATE_SPECULATION_STATS_EN
      chk("hit_count", 32'(hit_count), 32'(m_hit));
      chk("miss_count", 32'(miss_count), 32'(m_miss));
`endif
    end
  end

  // Apply one cycle of inputs; returns just after the following negedge.
  task automatic cyc(input logic r, input logic e, input logic iv, input logic ip,
                     input logic [2:0] t, input logic rv, input logic rval);
    reset = r; enable = e; issue_valid = iv; issue_prediction = ip; issue_tag = t;
    resolve_valid = rv; resolve_value = rval;
    @(negedge clock); #1;
  endtask

  task automatic issue(input logic ip, input logic [2:0] t);
    cyc(0, 1, 1, ip, t, 0, 0);
  endtask

  task automatic resolve(input logic v);
    cyc(0, 1, 0, 0, 0, 1, v);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  logic rv_r, rval_r;

  initial begin
    reset = 1; enable = 1; issue_valid = 0; issue_prediction = 0; issue_tag = '0;
    resolve_valid = 0; resolve_value = 0;
    @(negedge clock); #1;
    checking = 1;
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_count", 32'(outstanding_count), 32'd0);
    chk("reset_commit_tag", 32'(commit_tag), 32'd0);

    // Basic commit
    issue(1, 5);
    chk("basic_count1", 32'(outstanding_count), 32'd1);
    resolve(1);
    chk("basic_commit_valid", 32'(commit_valid), 32'd1);
    chk("basic_commit_tag", 32'(commit_tag), 32'd5);
    chk("basic_count0", 32'(outstanding_count), 32'd0);

    // Mispredict with queue and recovery window
    issue(0, 1); issue(0, 2); issue(0, 3);
    resolve(1);
    chk("mp_squash", 32'(squash), 32'd1);
    chk("mp_squash_tag", 32'(squash_tag), 32'd1);
    chk("mp_count", 32'(outstanding_count), 32'd0);
    chk("mp_ready_c1", 32'(issue_ready), 32'd0);
    idle();
    chk("mp_ready_c2", 32'(issue_ready), 32'd0);
    idle();
    chk("mp_ready_c3", 32'(issue_ready), 32'd1);

    // Full boundary
    for (int i = 0; i < 4; i++) issue(1, 3'(i));
    chk("full_ready", 32'(issue_ready), 32'd0);
    chk("full_count", 32'(outstanding_count), 32'd4);
    issue(1, 7);
    chk("full_drop_count", 32'(outstanding_count), 32'd4);
    cyc(0, 1, 1, 1, 6, 1, 1);
    chk("full_pop_tag", 32'(commit_tag), 32'd0);
    chk("full_pop_count", 32'(outstanding_count), 32'd3);
    resolve(1); resolve(1); resolve(1);
    chk("full_last_tag", 32'(commit_tag), 32'd3);
    chk("full_empty", 32'(outstanding_count), 32'd0);

    // Simultaneous issue and resolve
    issue(0, 1); issue(0, 2);
    cyc(0, 1, 1, 0, 4, 1, 0);
    chk("sim_match_count", 32'(outstanding_count), 32'd2);
    chk("sim_match_tag", 32'(commit_tag), 32'd1);
    cyc(0, 1, 1, 0, 5, 1, 1);
    chk("sim_miss_squash_tag", 32'(squash_tag), 32'd2);
    chk("sim_miss_count", 32'(outstanding_count), 32'd0);
    idle(); idle();

    // Empty resolve, then enable low during recovery
    resolve(1);
    chk("empty_commit", 32'(commit_valid), 32'd0);
    chk("empty_squash", 32'(squash), 32'd0);
    issue(0, 3);
    resolve(1);
    chk("en_squash", 32'(squash), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("en_pulse_off", 32'(squash), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("en_ready_frozen", 32'(issue_ready), 32'd0);
    idle();
    chk("en_ready_back", 32'(issue_ready), 32'd1);

    // Reset during recovery
    issue(0, 6);
    resolve(1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_squash", 32'(squash), 32'd0);
    chk("rst_squash_tag", 32'(squash_tag), 32'd0);

    // Stats: three hits, one miss
    for (int i = 0; i < 3; i++) begin
      issue(1, 3'(i + 1));
      resolve(1);
    end
    issue(1, 7);
    resolve(0);
`ifdef PREDICATE_SPECULATION_STATS_EN
    chk("stats_hit", 32'(hit_count), 32'd3);
    chk("stats_miss", 32'(miss_count), 32'd1);
`endif
    idle(); idle();

    // Randomized traffic, resolves biased toward matching the head prediction
    for (int n = 0; n < 3000; n++) begin
      rv_r = ($urandom_range(0, 9) < 4);
      rval_r = 1'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) rval_r = mq[0].p;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) < 6), 1'($urandom), 3'($urandom), rv_r, rval_r);
    end

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
